// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and the round-robin pick function for the stream arbiter.
// rr_pick scans a doubled request vector so the wrap-around search is a plain priority scan.
package rr_stream_arbiter_pkg;

    localparam int MAX_PORTS = 32;
    localparam int PTR_W     = 5;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Only the low n bits of valid may be set; the result is one-hot within n bits, or zero.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] valid,
        input logic [PTR_W-1:0]     ptr,
        input int                   n
    );
        logic [2*MAX_PORTS-1:0] dbl;
        logic [2*MAX_PORTS-1:0] masked;
        logic [MAX_PORTS-1:0]   pick;
        logic                   found;
        int                     first;
        int                     wrapped;
        int                     start;

        start = int'(ptr);
        dbl   = {{MAX_PORTS{1'b0}}, valid} | ({{MAX_PORTS{1'b0}}, valid} << n);

        masked = '0;
        for (int j = 0; j < 2*MAX_PORTS; j++) begin
            if (j >= start && j < start + n) begin
                masked[j] = dbl[j];
            end
        end

        found = 1'b0;
        first = 0;
        for (int j = 0; j < 2*MAX_PORTS; j++) begin
            if (!found && masked[j]) begin
                found = 1'b1;
                first = j;
            end
        end

        wrapped = (first >= n) ? first - n : first;

        pick = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            pick[i] = found && (i == wrapped);
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_stream_arbiter_onehot_mux.sv
// One-hot AND-OR data mux: each lane is gated by its select bit and the results OR-ed.
// A zero select yields zero data.
module rr_stream_arbiter_onehot_mux #(
    parameter int DATAWIDTH    = 4,
    parameter int SELECT_WIDTH = 4
) (
    input  logic [SELECT_WIDTH-1:0]           sel,
    input  logic [DATAWIDTH*SELECT_WIDTH-1:0] data,
    output logic [DATAWIDTH-1:0]              result
);

    always_comb begin
        result = '0;
        for (int i = 0; i < SELECT_WIDTH; i++) begin
            result = result | (data[DATAWIDTH*i +: DATAWIDTH] & {DATAWIDTH{sel[i]}});
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter: holds a grant from first beat to last beat, then rotates.
// The selected beat lands in a single output register slot that refills in the cycle it drains.
module rr_stream_arbiter
    import rr_stream_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 4,
    parameter int NUM_PORTS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS-1:0]           in_last,
    input  logic [DATAWIDTH*NUM_PORTS-1:0] in_data,
    output logic [NUM_PORTS-1:0]           in_ready,
    output logic                           out_valid,
    output logic                           out_last,
    output logic [DATAWIDTH-1:0]           out_data,
    output logic [NUM_PORTS-1:0]           out_src,
    input  logic                           out_ready
);

    state_t                 state;
    logic [PTR_W-1:0]       ptr;
    logic [NUM_PORTS-1:0]   lock_sel;

    logic [MAX_PORTS-1:0]   valid_ext;
    logic [MAX_PORTS-1:0]   pick_ext;
    logic                   unused_pick;
    logic [NUM_PORTS-1:0]   grant;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic [DATAWIDTH-1:0]   sel_data;
    logic                   sel_last;
    logic                   slot_free;
    logic                   xfer;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_PORTS-1:0] = in_valid;
    end

    assign pick_ext    = rr_pick(valid_ext, ptr, NUM_PORTS);
    assign unused_pick = ^pick_ext;

    // While locked the grant ignores in_valid so a stalled packet keeps every other port blocked.
    assign grant = (state == LOCK) ? lock_sel : pick_ext[NUM_PORTS-1:0];

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign next_ptr  = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    assign sel_last  = |(in_last & grant);
    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = rst ? '0 : (grant & {NUM_PORTS{slot_free}});
    assign xfer      = |(in_valid & in_ready);

    rr_stream_arbiter_onehot_mux #(
        .DATAWIDTH    (DATAWIDTH),
        .SELECT_WIDTH (NUM_PORTS)
    ) u_mux (
        .sel    (grant),
        .data   (in_data),
        .result (sel_data)
    );

    // Packet FSM, rotation pointer and output slot share one register block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            lock_sel  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_src   <= grant;
                case (state)
                    IDLE: begin
                        if (sel_last) begin
                            ptr <= next_ptr;
                        end else begin
                            state    <= LOCK;
                            lock_sel <= grant;
                        end
                    end
                    LOCK: begin
                        if (sel_last) begin
                            ptr   <= next_ptr;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (4 ports x 4 bits) with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_rr_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [DW*N-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    out_src;
    logic            out_ready;

    int errors = 0;
    int checks = 0;

    rr_stream_arbiter #(
        .DATAWIDTH (DW),
        .NUM_PORTS (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] last, input logic [DW*N-1:0] data);
        in_valid = valid;
        in_last  = last;
        in_data  = data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0]  rr_src  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [DW-1:0] rr_data [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    logic [N-1:0]  sp_src  [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    logic [DW-1:0] sp_data [4] = '{4'hB, 4'hD, 4'hB, 4'hD};

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 16'hDCBA);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_last", out_last, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset out_src", out_src, 0);
        checkOutput("reset in_ready", in_ready, 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("release in_ready", in_ready, 4'b0001);
        tick();
        checkOutput("pkt0 out_valid", out_valid, 1);
        checkOutput("pkt0 out_src", out_src, 4'b0001);
        checkOutput("pkt0 out_data", out_data, 4'hA);
        checkOutput("pkt0 out_last", out_last, 0);

        rst = 1'b1;
        #1;
        checkOutput("midpkt rst out_valid", out_valid, 0);
        checkOutput("midpkt rst in_ready", in_ready, 0);
        checkOutput("midpkt rst out_src", out_src, 0);
        rst = 1'b0;
        #1;
        checkOutput("post-rst first grant", in_ready, 4'b0001);

        applyStimulus(4'b1111, 4'b1111, 16'hDCBA);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("rr%0d out_valid", k), out_valid, 1);
            checkOutput($sformatf("rr%0d out_src", k), out_src, rr_src[k]);
            checkOutput($sformatf("rr%0d out_data", k), out_data, rr_data[k]);
        end

        applyStimulus(4'b0000, 4'b0000, 16'hDCBA);
        tick();
        checkOutput("drain out_valid", out_valid, 0);

        applyStimulus(4'b0010, 4'b0010, 16'h0050);
        tick();
        checkOutput("p1 single out_src", out_src, 4'b0010);
        checkOutput("p1 single out_data", out_data, 4'h5);

        applyStimulus(4'b0110, 4'b0000, 16'h0150);
        checkOutput("lock b1 in_ready", in_ready, 4'b0100);
        tick();
        checkOutput("lock b1 out_src", out_src, 4'b0100);
        checkOutput("lock b1 out_data", out_data, 4'h1);
        checkOutput("lock b1 out_last", out_last, 0);

        applyStimulus(4'b0110, 4'b0000, 16'h0250);
        checkOutput("lock b2 in_ready", in_ready, 4'b0100);
        tick();
        checkOutput("lock b2 out_data", out_data, 4'h2);

        applyStimulus(4'b0010, 4'b0000, 16'h0F50);
        checkOutput("lock gap in_ready", in_ready, 4'b0100);
        tick();
        checkOutput("lock gap out_valid", out_valid, 0);
        checkOutput("lock gap out_data hold", out_data, 4'h2);

        applyStimulus(4'b0110, 4'b0100, 16'h0350);
        checkOutput("lock b3 in_ready", in_ready, 4'b0100);
        tick();
        checkOutput("lock b3 out_data", out_data, 4'h3);
        checkOutput("lock b3 out_last", out_last, 1);
        checkOutput("lock b3 out_src", out_src, 4'b0100);

        applyStimulus(4'b0010, 4'b0010, 16'h0350);
        checkOutput("after lock in_ready", in_ready, 4'b0010);
        tick();
        checkOutput("after lock out_src", out_src, 4'b0010);
        checkOutput("after lock out_data", out_data, 4'h5);

        out_ready = 1'b0;
        applyStimulus(4'b1000, 4'b1000, 16'hD000);
        checkOutput("bp in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("bp%0d out_valid", k), out_valid, 1);
            checkOutput($sformatf("bp%0d out_src", k), out_src, 4'b0010);
            checkOutput($sformatf("bp%0d out_data", k), out_data, 4'h5);
            checkOutput($sformatf("bp%0d out_last", k), out_last, 1);
            checkOutput($sformatf("bp%0d in_ready", k), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp release in_ready", in_ready, 4'b1000);
        tick();
        checkOutput("bp release out_valid", out_valid, 1);
        checkOutput("bp release out_src", out_src, 4'b1000);
        checkOutput("bp release out_data", out_data, 4'hD);

        applyStimulus(4'b1001, 4'b1001, 16'hD00A);
        checkOutput("wrap in_ready", in_ready, 4'b0001);
        tick();
        checkOutput("wrap out_src", out_src, 4'b0001);
        checkOutput("wrap out_data", out_data, 4'hA);

        applyStimulus(4'b1010, 4'b1010, 16'hDCBA);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("sparse%0d in_ready", k), in_ready, sp_src[k]);
            tick();
            checkOutput($sformatf("sparse%0d out_src", k), out_src, sp_src[k]);
            checkOutput($sformatf("sparse%0d out_data", k), out_data, sp_data[k]);
        end

        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        tick();
        checkOutput("final drain out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- N-input round-robin packet arbiter with valid/ready streams in and one registered valid/ready stream out.
- Sits directly upstream of the team's one-hot data mux. It generates the one-hot select that drives that mux, then registers the selected beat.
- Grant is held for a whole packet, from first beat to the beat with last=1.

Parameters:
- DATAWIDTH, 4: payload width per input.
- NUM_PORTS, 4: number of input streams. Legal range is 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_PORTS  per-port beat valid.
- in_last  input  NUM_PORTS  per-port end-of-packet flag, qualified by in_valid.
- in_data  input  DATAWIDTH*NUM_PORTS  flattened payloads; port i occupies [DATAWIDTH*i +: DATAWIDTH].
- in_ready  output  NUM_PORTS  per-port accept.
- out_valid  output  1  registered beat valid.
- out_last  output  1  registered end-of-packet flag.
- out_data  output  DATAWIDTH  registered payload.
- out_src  output  NUM_PORTS  one-hot source port of the current out beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_last=0, out_data=0, out_src=0.
  - state=IDLE, priority pointer ptr=0 (port 0 highest priority).
  - in_ready is 0 while rst is high.
- Output slot:
  - slot_free = ~out_valid | out_ready.
  - in_ready = grant & {NUM_PORTS{slot_free}}.
  - Input beat i transfers when in_valid[i] & in_ready[i]. At most one port transfers per cycle.
- Grant (combinational, one-hot or zero):
  - IDLE: the first port with in_valid set, scanning from ptr upward and wrapping NUM_PORTS-1 to 0. Grant is zero if no port is valid.
  - LOCK: grant = lock_sel, whatever the in_valid values. If the locked port drops valid, no transfer occurs and other ports stay blocked.
- State machine:
  - IDLE -> LOCK on a transfer with in_last=0. lock_sel captures the granted one-hot.
  - IDLE stays IDLE on a transfer with in_last=1 (single-beat packet).
  - LOCK -> IDLE on a transfer from lock_sel with in_last=1.
  - LOCK stays LOCK otherwise.
- Pointer update:
  - On every transfer with in_last=1, ptr <= (granted index + 1) mod NUM_PORTS.
  - ptr is unchanged on non-last beats and on idle cycles.
  - Fairness: with all ports continuously requesting, packets are served strictly in rotation.
- Data path:
  - The selected beat is in_data masked and OR-ed by the one-hot grant, using the mux sub-module.
  - On transfer: out_data, out_last, out_src <= selected data, in_last[idx], grant; out_valid <= 1.
  - Otherwise, if out_ready=1: out_valid <= 0; out_data, out_last, out_src hold their values.
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 beat/cycle while out_ready=1.
  - Out registers are stable while out_valid & ~out_ready (backpressure). in_ready is 0 in that condition.
- Boundary conditions:
  - Simultaneous out_ready drain and new transfer: the new beat replaces the old one in the same cycle, with no bubble.
  - in_valid on an ungranted port is ignored; that port's in_ready stays 0.
  - Reset mid-packet: state returns to IDLE and ptr to 0; any in-flight out beat is discarded.
  - NUM_PORTS not a power of two: ptr wraps explicitly at NUM_PORTS-1.
  - Grant never has more than one bit set. Assertion: $onehot0(grant).

Decomposition:
- Package rr_stream_arbiter_pkg:
  - state enum {IDLE, LOCK}.
  - Function rr_pick(valid, ptr) returning a one-hot vector, implemented as a double-width mask-and-priority scan.
- One sub-module instance: the existing one-hot mux, with DATAWIDTH=DATAWIDTH and SELECT_WIDTH=NUM_PORTS, sel=grant.
- No other hierarchy.

Test Plan:
- Reset: assert rst mid-packet with in_valid=4'b1111 -> out_valid=0, in_ready=0, out_src=0. After release, the first grant goes to port 0.
- Round-robin: NUM_PORTS=4, all ports send single-beat packets continuously, out_ready=1 -> out_src sequence 0001, 0010, 0100, 1000, 0001. One beat per cycle, no bubbles.
- Packet lock:
  - Stimulus: port 2 sends 3 beats (last on the third); port 1 is valid throughout; port 2 inserts a gap cycle with in_valid=0 mid-packet.
  - Required: in_ready[1]=0 until port 2's last beat transfers. out_data shows port 2's beats in order. Port 1 is granted next.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data, out_last, out_src stable; all in_ready=0. out_ready=1 -> next beat is accepted the same cycle.
- Pointer wrap: only port 3 requests (single beat) -> ptr=0. Then ports 0 and 3 request together -> port 0 wins.
- Sparse requests: only ports 1 and 3 request, alternating single-beat packets -> grants alternate 0010, 1000. Unrequested ports are never granted.
